// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution window sequencer: FSM state
// encoding and default buffer geometry.
package cnn_pkg;

   // Default pixel width and buffer geometry (5x5 buffer, 3-bit addresses).
   localparam int DW_DEF       = 8;
   localparam int MEM_SIZE_DEF = 5;
   localparam int MEM_ADDR_DEF = 3;

   // Controller states, 2-bit binary in declaration order.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_SCAN = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage : cnn_pkg

// File: rtl/conv_window_sequencer_rc_counter.sv
// Row/column position counter stepping row-major over LO..HI in both axes.
// Reset puts it at (0,0); clr loads (LO,LO); inc advances one position and
// saturates on the final one so the address holds once the sweep is complete.
module rc_counter #(
   parameter int W  = 3,
   parameter int LO = 0,
   parameter int HI = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] row,
   output logic [W-1:0] col,
   output logic         last
);

   localparam logic [W-1:0] LO_V = W'(LO);
   localparam logic [W-1:0] HI_V = W'(HI);

   // Final position of the sweep.
   assign last = (row == HI_V) && (col == HI_V);

   // Position register: clear has priority over increment; column wraps into the next row.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state is always updated with non-blocking assignments so every
         // register samples pre-edge values regardless of block evaluation order.
         row <= '0;
         col <= '0;
      end else if (clr) begin
         row <= LO_V;
         col <= LO_V;
      end else if (inc && !last) begin
         if (col == HI_V) begin
            col <= LO_V;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule : rc_counter

// File: rtl/conv_window_sequencer.sv
// Sequencer for one MEM_SIZE x MEM_SIZE feature-map buffer: fills it from a
// pixel stream, then walks the 3x3 window centre over every interior position
// in row-major order and hands each window downstream. Writes happen only in
// LOAD and reads only in SCAN, so the two enables can never overlap.
module conv_window_sequencer
   import cnn_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int MEM_SIZE = MEM_SIZE_DEF,
   parameter int MEM_ADDR = MEM_ADDR_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   input  logic                pix_valid,
   input  logic signed [DW-1:0] pix_data,
   output logic                pix_ready,
   output logic                mem_wr_en,
   output logic [DW-1:0]       mem_data_in,
   output logic [MEM_ADDR-1:0] mem_in_add_row,
   output logic [MEM_ADDR-1:0] mem_in_add_col,
   output logic                mem_rd_en,
   output logic [MEM_ADDR-1:0] mem_a_add_row,
   output logic [MEM_ADDR-1:0] mem_a_add_col,
   output logic                win_valid,
   input  logic                win_ready,
   output logic                win_last
);

   state_t state, state_nxt;

   logic wr_clr, wr_inc, wr_last;
   logic rd_clr, rd_inc, rd_last;

   // Write-address counter: covers the whole buffer.
   rc_counter #(
      .W  (MEM_ADDR),
      .LO (0),
      .HI (MEM_SIZE - 1)
   ) u_wr_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (wr_clr),
      .inc   (wr_inc),
      .row   (mem_in_add_row),
      .col   (mem_in_add_col),
      .last  (wr_last)
   );

   // Window-centre counter: interior positions only, so every 3x3 window fits.
   rc_counter #(
      .W  (MEM_ADDR),
      .LO (1),
      .HI (MEM_SIZE - 2)
   ) u_rd_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (rd_clr),
      .inc   (rd_inc),
      .row   (mem_a_add_row),
      .col   (mem_a_add_col),
      .last  (rd_last)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state, counter control and handshake decode; abort overrides every transition.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave one
      // unassigned and infer a latch.
      state_nxt   = state;
      wr_clr      = 1'b0;
      wr_inc      = 1'b0;
      rd_clr      = 1'b0;
      rd_inc      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      pix_ready   = 1'b0;
      mem_wr_en   = 1'b0;
      mem_data_in = '0;
      mem_rd_en   = 1'b0;
      win_valid   = 1'b0;
      win_last    = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_LOAD;
               wr_clr    = 1'b1;
            end
         end
         S_LOAD: begin
            busy        = 1'b1;
            pix_ready   = 1'b1;
            mem_wr_en   = pix_valid;
            mem_data_in = pix_data;
            if (pix_valid) begin
               wr_inc = 1'b1;
               if (wr_last) begin
                  state_nxt = S_SCAN;
                  rd_clr    = 1'b1;
               end
            end
         end
         S_SCAN: begin
            busy      = 1'b1;
            mem_rd_en = 1'b1;
            win_valid = 1'b1;
            win_last  = rd_last;
            if (win_ready) begin
               rd_inc = 1'b1;
               if (rd_last) state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      // Abort still lets the write of this cycle through; it only redirects the
      // state and clears both position counters.
      if (abort) begin
         state_nxt = S_IDLE;
         wr_clr    = 1'b1;
         wr_inc    = 1'b0;
         rd_clr    = 1'b1;
         rd_inc    = 1'b0;
      end
   end

endmodule : conv_window_sequencer

// File: tb/tb_conv_window_sequencer.sv
// Directed self-checking bench for conv_window_sequencer (DW=8, 5x5 buffer).
module tb_conv_window_sequencer;

   localparam int DW = 8;
   localparam int MA = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          busy, done;
   logic          pix_valid = 1'b0;
   logic [DW-1:0] pix_data = '0;
   logic          pix_ready;
   logic          mem_wr_en;
   logic [DW-1:0] mem_data_in;
   logic [MA-1:0] mem_in_add_row, mem_in_add_col;
   logic          mem_rd_en;
   logic [MA-1:0] mem_a_add_row, mem_a_add_col;
   logic          win_valid;
   logic          win_ready = 1'b0;
   logic          win_last;

   int checks = 0;
   int errors = 0;

   conv_window_sequencer #(.DW(8), .MEM_SIZE(5), .MEM_ADDR(3)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .abort          (abort),
      .busy           (busy),
      .done           (done),
      .pix_valid      (pix_valid),
      .pix_data       (pix_data),
      .pix_ready      (pix_ready),
      .mem_wr_en      (mem_wr_en),
      .mem_data_in    (mem_data_in),
      .mem_in_add_row (mem_in_add_row),
      .mem_in_add_col (mem_in_add_col),
      .mem_rd_en      (mem_rd_en),
      .mem_a_add_row  (mem_a_add_row),
      .mem_a_add_col  (mem_a_add_col),
      .win_valid      (win_valid),
      .win_ready      (win_ready),
      .win_last       (win_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs at the falling edge; outputs are sampled 1 ns later.
   task automatic drive(input logic s, input logic a, input logic pv,
                        input logic [DW-1:0] pd, input logic wr);
      @(negedge clk);
      start     = s;
      abort     = a;
      pix_valid = pv;
      pix_data  = pd;
      win_ready = wr;
      #1;
      check("excl", 32'(mem_wr_en & mem_rd_en), 32'(0));
   endtask

   task automatic check_wr(input string tag, input int idx, input logic en);
      check({tag, "_wr_en"}, 32'(mem_wr_en), 32'(en));
      check({tag, "_row"}, 32'(mem_in_add_row), 32'(idx / 5));
      check({tag, "_col"}, 32'(mem_in_add_col), 32'(idx % 5));
   endtask

   // Start cycle plus 25 back-to-back beats carrying r*5+c-12.
   task automatic load_full(input string tag);
      logic [DW-1:0] d;
      drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
      check({tag, "_start_busy"}, 32'(busy), 32'(0));
      for (int i = 0; i < 25; i++) begin
         d = DW'(i - 12);
         drive(1'b0, 1'b0, 1'b1, d, 1'b1);
         check_wr(tag, i, 1'b1);
         check({tag, "_data"}, 32'(mem_data_in), 32'(d));
         check({tag, "_rd_en"}, 32'(mem_rd_en), 32'(0));
      end
   endtask

   // Nine windows; optional stall of n cycles on window k_stall; optional
   // start pulse on window k_start. Ends with the done cycle and one idle cycle.
   task automatic scan_frame(input string tag, input int k_stall, input int n_stall,
                             input int k_start);
      for (int k = 0; k < 9; k++) begin
         if (k == k_stall) begin
            for (int s = 0; s < n_stall; s++) begin
               drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
               check({tag, "_hold_valid"}, 32'(win_valid), 32'(1));
               check({tag, "_hold_row"}, 32'(mem_a_add_row), 32'(1 + k / 3));
               check({tag, "_hold_col"}, 32'(mem_a_add_col), 32'(1 + k % 3));
               check({tag, "_hold_last"}, 32'(win_last), 32'(0));
            end
         end
         drive(k == k_start, 1'b0, 1'b0, '0, 1'b1);
         check({tag, "_rd_en"}, 32'(mem_rd_en), 32'(1));
         check({tag, "_win_valid"}, 32'(win_valid), 32'(1));
         check({tag, "_c_row"}, 32'(mem_a_add_row), 32'(1 + k / 3));
         check({tag, "_c_col"}, 32'(mem_a_add_col), 32'(1 + k % 3));
         check({tag, "_win_last"}, 32'(win_last), 32'(k == 8));
         check({tag, "_wr_en"}, 32'(mem_wr_en), 32'(0));
      end
      drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
      check({tag, "_done"}, 32'(done), 32'(1));
      check({tag, "_done_busy"}, 32'(busy), 32'(0));
      drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
      check({tag, "_done_once"}, 32'(done), 32'(0));
      check({tag, "_idle_busy"}, 32'(busy), 32'(0));
   endtask

   initial begin
      int            acc;
      logic          pv;
      logic [DW-1:0] d;

      // Reset state.
      #12;
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_pix_ready", 32'(pix_ready), 32'(0));
      check("rst_wr_en", 32'(mem_wr_en), 32'(0));
      check("rst_rd_en", 32'(mem_rd_en), 32'(0));
      check("rst_win_valid", 32'(win_valid), 32'(0));
      check("rst_win_last", 32'(win_last), 32'(0));
      check("rst_addr", 32'({mem_in_add_row, mem_in_add_col, mem_a_add_row, mem_a_add_col}), 32'(0));
      check("rst_data", 32'(mem_data_in), 32'(0));
      @(negedge clk);
      reset = 1'b1;

      // Full frame with no stalls: start cycle + 25 LOAD + 9 SCAN, done in the 36th cycle.
      load_full("full");
      scan_frame("full", -1, 0, -1);

      // Upstream gaps: pix_valid toggles; counter moves only on accepted beats.
      drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
      acc = 0;
      for (int i = 0; i < 49; i++) begin
         pv = (i % 2 == 0);
         d  = DW'(acc - 12);
         drive(1'b0, 1'b0, pv, d, 1'b1);
         check_wr("gap", acc, pv);
         if (pv) begin
            check("gap_data", 32'(mem_data_in), 32'(d));
            acc++;
         end
      end
      check("gap_writes", 32'(acc), 32'(25));
      scan_frame("gap", -1, 0, -1);

      // Downstream backpressure: 4 stall cycles on centre (2,2), then (2,3).
      load_full("bp");
      scan_frame("bp", 4, 4, -1);

      // Abort during LOAD after 10 pixels; the write in the abort cycle still happens.
      drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 1'b1, DW'(i), 1'b1);
         check_wr("ab_load", i, 1'b1);
      end
      drive(1'b0, 1'b1, 1'b1, 8'h5a, 1'b1);
      check_wr("ab_cycle", 10, 1'b1);
      check("ab_cycle_data", 32'(mem_data_in), 32'(8'h5a));
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, '0, 1'b1);
         check("ab_busy", 32'(busy), 32'(0));
         check("ab_done", 32'(done), 32'(0));
         check("ab_pix_ready", 32'(pix_ready), 32'(0));
         check_wr("ab_idle", 0, 1'b0);
      end
      // Fresh start restarts writes at (0,0).
      load_full("ab_restart");
      scan_frame("ab_restart", -1, 0, -1);

      // Reset mid-SCAN at centre (2,1).
      load_full("rs");
      for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
      check("rs_c_row", 32'(mem_a_add_row), 32'(2));
      check("rs_c_col", 32'(mem_a_add_col), 32'(1));
      reset = 1'b0;
      #1;
      check("rs_busy", 32'(busy), 32'(0));
      check("rs_rd_en", 32'(mem_rd_en), 32'(0));
      check("rs_win_valid", 32'(win_valid), 32'(0));
      check("rs_win_last", 32'(win_last), 32'(0));
      check("rs_addr", 32'({mem_in_add_row, mem_in_add_col, mem_a_add_row, mem_a_add_col}), 32'(0));
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b1, '0, 1'b1);
         check("rs_idle_busy", 32'(busy), 32'(0));
         check("rs_idle_ready", 32'(pix_ready), 32'(0));
         check("rs_idle_done", 32'(done), 32'(0));
      end

      // Start pulsed during SCAN (centre (2,2)) changes nothing; exactly one done.
      load_full("ign");
      scan_frame("ign", -1, 0, 4);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
         check("ign_after_busy", 32'(busy), 32'(0));
         check("ign_after_done", 32'(done), 32'(0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_conv_window_sequencer
